// File: rtl/rs_alu.sv
// rtl/rs_alu.sv - ALU reservation station: buffers issued ops, snoops the CDB, dispatches one ready op per cycle.
// Optional age-ordered dispatch selection is enabled by defining RS_ALU_AGE_ORDER_EN.
module rs_alu #(
    parameter int RS_SIZE  = 8,
    parameter int ROB_ID_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                alu_in_en,
    input  logic [4:0]          alu_op_type,
    input  logic [ROB_ID_W-1:0] vdest_id,
    input  logic                op1_dependent,
    input  logic [31:0]         op1,
    input  logic                op2_dependent,
    input  logic [31:0]         op2,
    input  logic                cdb_en,
    input  logic [ROB_ID_W-1:0] cdb_id,
    input  logic [31:0]         cdb_val,
    output logic                rs_alu_full,
    output logic                alu_out_en,
    output logic [4:0]          alu_out_op_type,
    output logic [31:0]         alu_out_op1,
    output logic [31:0]         alu_out_op2,
    output logic [ROB_ID_W-1:0] alu_out_dest
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_SIZE-1:0]  busy_q, busy_d;
    logic [RS_SIZE-1:0]  q1_q, q1_d;
    logic [RS_SIZE-1:0]  q2_q, q2_d;
    logic [4:0]          op_type_q [RS_SIZE];
    logic [4:0]          op_type_d [RS_SIZE];
    logic [ROB_ID_W-1:0] dest_q    [RS_SIZE];
    logic [ROB_ID_W-1:0] dest_d    [RS_SIZE];
    logic [31:0]         v1_q      [RS_SIZE];
    logic [31:0]         v1_d      [RS_SIZE];
    logic [31:0]         v2_q      [RS_SIZE];
    logic [31:0]         v2_d      [RS_SIZE];
`ifdef RS_ALU_AGE_ORDER_EN
    logic [CNT_W-1:0]    age_q     [RS_SIZE];
    logic [CNT_W-1:0]    age_d     [RS_SIZE];
    logic [CNT_W-1:0]    best_age;
`endif

    logic                out_en_q, out_en_d;
    logic [4:0]          out_op_type_q, out_op_type_d;
    logic [31:0]         out_op1_q, out_op1_d;
    logic [31:0]         out_op2_q, out_op2_d;
    logic [ROB_ID_W-1:0] out_dest_q, out_dest_d;

    logic [CNT_W-1:0]    free_cnt;
    logic [RS_SIZE-1:0]  ready;
    logic                alloc_found, sel_found;
    logic [IDX_W-1:0]    alloc_idx, sel_idx;
    logic                fwd1, fwd2;

    // Free count and ready mask come only from registered state.
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_cnt = free_cnt + CNT_W'(!busy_q[i]);
        end
        ready = busy_q & ~q1_q & ~q2_q;
    end

    assign rs_alu_full = (free_cnt == '0) || ((free_cnt == CNT_W'(1)) && alu_in_en);

    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
    end

`ifdef RS_ALU_AGE_ORDER_EN
    // Strict greater-than while scanning upward keeps the lowest index on ties.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && (!sel_found || (age_q[i] > best_age))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                best_age  = age_q[i];
            end
        end
    end
`else
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end
`endif

    assign fwd1 = op1_dependent && cdb_en && (cdb_id == op1[ROB_ID_W-1:0]);
    assign fwd2 = op2_dependent && cdb_en && (cdb_id == op2[ROB_ID_W-1:0]);

    always_comb begin
        busy_d        = busy_q;
        q1_d          = q1_q;
        q2_d          = q2_q;
        op_type_d     = op_type_q;
        dest_d        = dest_q;
        v1_d          = v1_q;
        v2_d          = v2_q;
`ifdef RS_ALU_AGE_ORDER_EN
        age_d         = age_q;
`endif
        out_en_d      = 1'b0;
        out_op_type_d = out_op_type_q;
        out_op1_d     = out_op1_q;
        out_op2_d     = out_op2_q;
        out_dest_d    = out_dest_q;

        if (clr) begin
            busy_d = '0;
        end else begin
            if (cdb_en) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i] && q1_q[i] && (v1_q[i][ROB_ID_W-1:0] == cdb_id)) begin
                        q1_d[i] = 1'b0;
                        v1_d[i] = cdb_val;
                    end
                    if (busy_q[i] && q2_q[i] && (v2_q[i][ROB_ID_W-1:0] == cdb_id)) begin
                        q2_d[i] = 1'b0;
                        v2_d[i] = cdb_val;
                    end
                end
            end

            if (sel_found) begin
                out_en_d        = 1'b1;
                out_op_type_d   = op_type_q[sel_idx];
                out_op1_d       = v1_q[sel_idx];
                out_op2_d       = v2_q[sel_idx];
                out_dest_d      = dest_q[sel_idx];
                busy_d[sel_idx] = 1'b0;
            end

            // The allocated slot is free in registered state, so it never collides with dispatch.
            if (alu_in_en && alloc_found) begin
`ifdef RS_ALU_AGE_ORDER_EN
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i] && (age_q[i] != '1)) begin
                        age_d[i] = age_q[i] + CNT_W'(1);
                    end
                end
                age_d[alloc_idx] = '0;
`endif
                busy_d[alloc_idx]    = 1'b1;
                op_type_d[alloc_idx] = alu_op_type;
                dest_d[alloc_idx]    = vdest_id;
                q1_d[alloc_idx]      = op1_dependent && !fwd1;
                v1_d[alloc_idx]      = fwd1 ? cdb_val : op1;
                q2_d[alloc_idx]      = op2_dependent && !fwd2;
                v2_d[alloc_idx]      = fwd2 ? cdb_val : op2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q        <= '0;
            q1_q          <= '0;
            q2_q          <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_type_q[i] <= '0;
                dest_q[i]    <= '0;
                v1_q[i]      <= '0;
                v2_q[i]      <= '0;
`ifdef RS_ALU_AGE_ORDER_EN
                age_q[i]     <= '0;
`endif
            end
            out_en_q      <= 1'b0;
            out_op_type_q <= '0;
            out_op1_q     <= '0;
            out_op2_q     <= '0;
            out_dest_q    <= '0;
        end else begin
            busy_q        <= busy_d;
            q1_q          <= q1_d;
            q2_q          <= q2_d;
            op_type_q     <= op_type_d;
            dest_q        <= dest_d;
            v1_q          <= v1_d;
            v2_q          <= v2_d;
`ifdef RS_ALU_AGE_ORDER_EN
            age_q         <= age_d;
`endif
            out_en_q      <= out_en_d;
            out_op_type_q <= out_op_type_d;
            out_op1_q     <= out_op1_d;
            out_op2_q     <= out_op2_d;
            out_dest_q    <= out_dest_d;
        end
    end

    assign alu_out_en      = out_en_q;
    assign alu_out_op_type = out_op_type_q;
    assign alu_out_op1     = out_op1_q;
    assign alu_out_op2     = out_op2_q;
    assign alu_out_dest    = out_dest_q;

endmodule

// File: tb/tb_rs_alu.sv
// tb/tb_rs_alu.sv - scoreboard testbench for rs_alu; honours RS_ALU_AGE_ORDER_EN for dispatch order.
module tb_rs_alu;

    localparam int RS_SIZE = 8;

    logic        clk = 1'b0;
    logic        rst, clr, alu_in_en, op1_dependent, op2_dependent, cdb_en;
    logic [4:0]  alu_op_type, vdest_id, cdb_id;
    logic [31:0] op1, op2, cdb_val;
    logic        rs_alu_full, alu_out_en;
    logic [4:0]  alu_out_op_type, alu_out_dest;
    logic [31:0] alu_out_op1, alu_out_op2;

    typedef struct packed {
        logic [4:0]  t;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  d;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    rs_alu #(.RS_SIZE(RS_SIZE), .ROB_ID_W(5)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .alu_in_en(alu_in_en), .alu_op_type(alu_op_type), .vdest_id(vdest_id),
        .op1_dependent(op1_dependent), .op1(op1),
        .op2_dependent(op2_dependent), .op2(op2),
        .cdb_en(cdb_en), .cdb_id(cdb_id), .cdb_val(cdb_val),
        .rs_alu_full(rs_alu_full), .alu_out_en(alu_out_en),
        .alu_out_op_type(alu_out_op_type), .alu_out_op1(alu_out_op1),
        .alu_out_op2(alu_out_op2), .alu_out_dest(alu_out_dest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] t, input logic d1, input logic [31:0] a,
                         input logic d2, input logic [31:0] b, input logic [4:0] dst);
        alu_in_en     = 1'b1;
        alu_op_type   = t;
        op1_dependent = d1;
        op1           = a;
        op2_dependent = d2;
        op2           = b;
        vdest_id      = dst;
    endtask

    task automatic idle();
        alu_in_en     = 1'b0;
        op1_dependent = 1'b0;
        op2_dependent = 1'b0;
        cdb_en        = 1'b0;
    endtask

    task automatic bcast(input logic [4:0] id, input logic [31:0] val);
        cdb_en  = 1'b1;
        cdb_id  = id;
        cdb_val = val;
    endtask

    task automatic push(input logic [4:0] t, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        exp_t e;
        e.t = t; e.a = a; e.b = b; e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every dispatch must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && alu_out_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_dispatch: got dest %0h op1 %0h required no dispatch", alu_out_dest, alu_out_op1);
                end else begin
                    e = exp_q.pop_front();
                    chk("disp_type", {27'd0, alu_out_op_type}, {27'd0, e.t});
                    chk("disp_op1", alu_out_op1, e.a);
                    chk("disp_op2", alu_out_op2, e.b);
                    chk("disp_dest", {27'd0, alu_out_dest}, {27'd0, e.d});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0;
        alu_op_type = '0; vdest_id = '0; op1 = '0; op2 = '0; cdb_id = '0; cdb_val = '0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_en", {31'd0, alu_out_en}, 0);
        chk("rst_op_type", {27'd0, alu_out_op_type}, 0);
        chk("rst_op1", alu_out_op1, 0);
        chk("rst_op2", alu_out_op2, 0);
        chk("rst_dest", {27'd0, alu_out_dest}, 0);
        chk("rst_full", {31'd0, rs_alu_full}, 0);
        rst = 1'b0;
        tick();

        // Independent ADD: dispatch two edges after issue.
        drive(5'b00000, 0, 32'd7, 0, 32'd9, 5'd3);
        push(5'b00000, 32'd7, 32'd9, 5'd3);
        #1 chk("t1_full_issue", {31'd0, rs_alu_full}, 0);
        tick(); idle();
        chk("t1_no_early", {31'd0, alu_out_en}, 0);
        tick();
        chk("t1_dispatch", {31'd0, alu_out_en}, 1);
        chk("t1_full", {31'd0, rs_alu_full}, 0);

        // op1 waits on ROB id 5.
        tick();
        drive(5'b00001, 1, 32'd5, 0, 32'd2, 5'd6);
        push(5'b00001, 32'h10, 32'd2, 5'd6);
        tick(); idle();
        tick();
        chk("t2_wait", {31'd0, alu_out_en}, 0);
        bcast(5'd5, 32'h10);
        tick(); idle();
        chk("t2_wait2", {31'd0, alu_out_en}, 0);
        tick();
        chk("t2_dispatch", {31'd0, alu_out_en}, 1);

        // op2 forwarded from the CDB in the issue cycle.
        tick();
        drive(5'b00110, 0, 32'h55, 1, 32'd4, 5'd7);
        bcast(5'd4, 32'hAB);
        push(5'b00110, 32'h55, 32'hAB, 5'd7);
        tick(); idle();
        tick();
        chk("t3_dispatch", {31'd0, alu_out_en}, 1);
        bcast(5'd4, 32'hCD);
        tick(); idle();
        tick();
        chk("t3_no_redispatch", {31'd0, alu_out_en}, 0);

        // Fill all entries, try an overflow write, then drain.
        for (int i = 0; i < RS_SIZE; i++) begin
            drive(5'b00010, 1, 32'd30, 0, 32'd100 + 32'(i), 5'(8 + i));
            push(5'b00010, 32'h77, 32'd100 + 32'(i), 5'(8 + i));
            #1;
            if (i == RS_SIZE - 1) chk("t4_full_last_issue", {31'd0, rs_alu_full}, 1);
            else                  chk("t4_full_filling", {31'd0, rs_alu_full}, 0);
            tick();
        end
        idle();
        #1 chk("t4_full_held", {31'd0, rs_alu_full}, 1);
        drive(5'b00011, 0, 32'd1, 0, 32'd2, 5'd31);
        #1 chk("t4_full_overflow", {31'd0, rs_alu_full}, 1);
        tick(); idle();
        bcast(5'd30, 32'h77);
        tick(); idle();
        chk("t4_full_after_wake", {31'd0, rs_alu_full}, 1);
        chk("t4_no_disp_wake", {31'd0, alu_out_en}, 0);
        tick();
        chk("t4_first_disp", {31'd0, alu_out_en}, 1);
        chk("t4_full_freed", {31'd0, rs_alu_full}, 0);
        repeat (RS_SIZE + 2) tick();

        // clr with simultaneous issue and broadcast.
        for (int i = 0; i < 3; i++) begin
            drive(5'b00100, 1, 32'd29, 0, 32'd1, 5'(i));
            tick();
        end
        drive(5'b00101, 0, 32'd3, 0, 32'd4, 5'd9);
        bcast(5'd29, 32'h42);
        clr = 1'b1;
        tick(); idle(); clr = 1'b0;
        chk("t5_out_en", {31'd0, alu_out_en}, 0);
        chk("t5_full", {31'd0, rs_alu_full}, 0);
        bcast(5'd29, 32'h42);
        tick(); idle();
        tick();
        chk("t5_no_disp", {31'd0, alu_out_en}, 0);
        repeat (3) tick();

        // A (idx 2, older) and B (idx 0, newer) woken together.
        drive(5'b00111, 1, 32'd20, 0, 32'd3, 5'd20);
        push(5'b00111, 32'd1, 32'd3, 5'd20);
        tick();
        drive(5'b00111, 1, 32'd21, 0, 32'd4, 5'd21);
        push(5'b00111, 32'd2, 32'd4, 5'd21);
        tick();
        drive(5'b10000, 1, 32'd9, 0, 32'hA, 5'd2);
        tick(); idle();
        bcast(5'd20, 32'd1);
        tick(); idle();
        bcast(5'd21, 32'd2);
        tick(); idle();
        tick();
        drive(5'b01000, 1, 32'd9, 0, 32'hB, 5'h10);
        tick(); idle();
`ifdef RS_ALU_AGE_ORDER_EN
        push(5'b10000, 32'h99, 32'hA, 5'd2);
        push(5'b01000, 32'h99, 32'hB, 5'h10);
`else
        push(5'b01000, 32'h99, 32'hB, 5'h10);
        push(5'b10000, 32'h99, 32'hA, 5'd2);
`endif
        bcast(5'd9, 32'h99);
        tick(); idle();
        tick();
        chk("t6_first", {31'd0, alu_out_en}, 1);
        tick();
        chk("t6_second", {31'd0, alu_out_en}, 1);

        for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
        repeat (3) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
